uart_baud_cfg_ctrl: RTL

Baud configuration controller for the CoreUARTapb clock generator. It owns the generator's `baud_val` / `BAUD_VAL_FRACTION` inputs and accepts software writes into a shadow register. It commits those writes only when the UART is idle, so a character is never split across two rates. Optionally it measures a received start bit and derives the divider automatically (autobaud).

---
 rtl/uart_baud_cfg_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_baud_cfg_ctrl.sv
// Baud configuration controller: shadows software divider writes and commits them only while the UART is idle.
// Optional autobaud start-bit measurement is compiled in with `define UART_BAUD_CFG_AUTOBAUD_EN.
module uart_baud_cfg_ctrl #(
  parameter logic [12:0] RESET_BAUD_VAL = 13'd26,
  parameter logic [2:0]  RESET_FRACTION = 3'd0,
  parameter int          AB_MIN_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cfg_wr,
  input  logic [12:0] cfg_baud_val,
  input  logic [2:0]  cfg_fraction,
  input  logic        autobaud_start,
  input  logic        rx,
  input  logic        uart_idle,
  output logic [12:0] baud_val,
  output logic [2:0]  baud_val_fraction,
  output logic        cfg_update,
  output logic        busy,
  output logic        ab_done,
  output logic        ab_err
);

`ifdef UART_BAUD_CFG_AUTOBAUD_EN
  typedef enum logic [2:0] {IDLE, PEND, APPLY, AB_ARM, AB_FALL, AB_MEAS, AB_CALC} state_t;
`else
  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;
`endif

  state_t      state, state_nxt;
  logic [12:0] shd_baud;
  logic [2:0]  shd_frac;

`ifdef UART_BAUD_CFG_AUTOBAUD_EN
  localparam logic [16:0] W_MAX = 17'h1FFFF;
  logic        rx_q1, rx_s;
  logic [16:0] w;
  logic        w_sat, ab_ok, shd_ab;

  assign w_sat = (w == W_MAX);
  assign ab_ok = !w_sat && (w >= 17'(AB_MIN_WIDTH));

  // rx is asynchronous; idle line level is 1
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) w <= '0;
    else if (state == AB_FALL) w <= '0;
    else if (state == AB_MEAS && !rx_s && !w_sat) w <= w + 17'd1;
  end
`else
  logic unused_ab;
  assign unused_ab = ^{autobaud_start, rx, 17'(AB_MIN_WIDTH)};
`endif

  // A software write preempts everything except an APPLY already in progress,
  // whose old shadow still lands while the new one waits in PEND.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_wr) state_nxt = PEND;
`ifdef UART_BAUD_CFG_AUTOBAUD_EN
        else if (autobaud_start) state_nxt = AB_ARM;
`endif
      end
      PEND:  if (uart_idle) state_nxt = APPLY;
      APPLY: state_nxt = cfg_wr ? PEND : IDLE;
`ifdef UART_BAUD_CFG_AUTOBAUD_EN
      AB_ARM:  if (cfg_wr) state_nxt = PEND; else if (rx_s) state_nxt = AB_FALL;
      AB_FALL: if (cfg_wr) state_nxt = PEND; else if (!rx_s) state_nxt = AB_MEAS;
      AB_MEAS: if (cfg_wr) state_nxt = PEND; else if (rx_s || w_sat) state_nxt = AB_CALC;
      AB_CALC: state_nxt = (cfg_wr || ab_ok) ? PEND : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      shd_baud <= RESET_BAUD_VAL;
      shd_frac <= RESET_FRACTION;
`ifdef UART_BAUD_CFG_AUTOBAUD_EN
      shd_ab   <= 1'b0;
`endif
    end else if (cfg_wr) begin
      shd_baud <= cfg_baud_val;
      shd_frac <= cfg_fraction;
`ifdef UART_BAUD_CFG_AUTOBAUD_EN
      shd_ab   <= 1'b0;
    end else if (state == AB_CALC && ab_ok) begin
      // bit period = 16*(baud_val+1) + 2*fraction
      shd_baud <= w[16:4] - 13'd1;
      shd_frac <= w[3:1];
      shd_ab   <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      baud_val          <= RESET_BAUD_VAL;
      baud_val_fraction <= RESET_FRACTION;
      cfg_update        <= 1'b0;
    end else begin
      cfg_update <= (state == APPLY);
      if (state == APPLY) begin
        baud_val          <= shd_baud;
        baud_val_fraction <= shd_frac;
      end
    end
  end

`ifdef UART_BAUD_CFG_AUTOBAUD_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ab_done <= 1'b0;
      ab_err  <= 1'b0;
    end else begin
      ab_done <= (state == APPLY) && shd_ab;
      ab_err  <= (state == AB_CALC) && !cfg_wr && !ab_ok;
    end
  end
`else
  assign ab_done = 1'b0;
  assign ab_err  = 1'b0;
`endif

endmodule
